// File: rtl/pacman_clk_pkg.sv
// Shared types and constants for the Pacman clock-enable sequencer.
package pacman_clk_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_PAUSE     = 3'd4
    } clk_state_e;

    localparam logic [1:0] PH_ENA6 = 2'd0;
    localparam logic [1:0] PH_LAST = 2'd2;

    function automatic logic [1:0] ph_advance(input logic [1:0] ph);
        return (ph == PH_LAST) ? PH_ENA6 : ph + 2'd1;
    endfunction

endpackage

// File: rtl/pacman_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module pacman_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pacman_clk_ctrl.sv
// Start-up sequencer and 12.288/6.144/3.072 MHz clock-enable scheduler with a
// debug pause that stops only on a CPU-cycle boundary.
module pacman_clk_ctrl
    import pacman_clk_pkg::*;
#(
    parameter int LOCK_CYCLES = 16,
    parameter int RESET_HOLD  = 1024
) (
    input  logic       I_CLK,
    input  logic       I_RESET_L,
    input  logic       I_LOCKED,
    input  logic       I_PAUSE,
    output logic       O_ENA_12,
    output logic       O_ENA_6,
    output logic       O_ENA_CPU,
    output logic       O_RESET,
    output logic       O_PAUSED,
    output logic [2:0] O_STATE
);

    localparam int FCW = $clog2(LOCK_CYCLES + 1);
    localparam int PCW = $clog2(RESET_HOLD + 1);
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(LOCK_CYCLES - 1);
    localparam logic [FCW-1:0] FCNT_MAX  = FCW'(LOCK_CYCLES);
    localparam logic [PCW-1:0] PCNT_MAX  = PCW'(RESET_HOLD);

    logic lk_s;
    logic pz_s;

    clk_state_e     state, state_nx;
    logic [1:0]     ph, ph_nx;
    logic           cpu_tog, cpu_tog_nx;
    logic [FCW-1:0] fcnt, fcnt_nx;
    logic [PCW-1:0] pcnt, pcnt_nx;
    logic           running;

    logic en_nx, ena_12_d, ena_6_d, ena_cpu_d, reset_d, paused_d;

    pacman_sync2 u_sync_lock (
        .clk   (I_CLK),
        .rst_n (I_RESET_L),
        .d     (I_LOCKED),
        .q     (lk_s)
    );

    pacman_sync2 u_sync_pause (
        .clk   (I_CLK),
        .rst_n (I_RESET_L),
        .d     (I_PAUSE),
        .q     (pz_s)
    );

    assign running = (state == ST_HOLD) || (state == ST_RUN);

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state   <= ST_WAIT_LOCK;
            ph      <= PH_ENA6;
            cpu_tog <= 1'b1;
            fcnt    <= '0;
            pcnt    <= '0;
        end else begin
            state   <= state_nx;
            ph      <= ph_nx;
            cpu_tog <= cpu_tog_nx;
            fcnt    <= fcnt_nx;
            pcnt    <= pcnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ph_nx      = ph;
        cpu_tog_nx = cpu_tog;
        fcnt_nx    = fcnt;
        pcnt_nx    = pcnt;

        // Phase and CPU toggle only move while enables are being issued.
        if (running) begin
            ph_nx = ph_advance(ph);
            if (ph == PH_ENA6) begin
                cpu_tog_nx = ~cpu_tog;
            end
        end

        case (state)
            ST_WAIT_LOCK: begin
                ph_nx      = PH_ENA6;
                cpu_tog_nx = 1'b1;
                fcnt_nx    = '0;
                pcnt_nx    = '0;
                if (lk_s) begin
                    state_nx = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (!lk_s) begin
                    state_nx = ST_WAIT_LOCK;
                    fcnt_nx  = '0;
                end else begin
                    if (fcnt < FCNT_MAX) begin
                        fcnt_nx = fcnt + FCW'(1);
                    end
                    if (fcnt >= FCNT_LAST) begin
                        state_nx = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if ((ph == PH_ENA6) && (pcnt < PCNT_MAX)) begin
                    pcnt_nx = pcnt + PCW'(1);
                end
                // Leaving at the end of a period makes the first RUN cycle ph=0.
                if ((ph == PH_LAST) && (pcnt == PCNT_MAX)) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pz_s && (ph == PH_LAST) && cpu_tog) begin
                    state_nx = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!pz_s) begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_WAIT_LOCK;
            end
        endcase

        // Lock loss overrides any other transition, including a pause boundary.
        if (!lk_s && (state != ST_WAIT_LOCK) && (state != ST_FILTER)) begin
            state_nx   = ST_WAIT_LOCK;
            ph_nx      = PH_ENA6;
            cpu_tog_nx = 1'b1;
            fcnt_nx    = '0;
            pcnt_nx    = '0;
        end
    end

    // Outputs are registered copies of the decode of the next state.
    always_comb begin
        en_nx     = (state_nx == ST_HOLD) || (state_nx == ST_RUN);
        ena_12_d  = en_nx && (ph_nx != PH_LAST);
        ena_6_d   = en_nx && (ph_nx == PH_ENA6);
        ena_cpu_d = ena_6_d && cpu_tog_nx;
        reset_d   = (state_nx == ST_WAIT_LOCK) || (state_nx == ST_FILTER) ||
                    (state_nx == ST_HOLD);
        paused_d  = (state_nx == ST_PAUSE);
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            O_ENA_12  <= 1'b0;
            O_ENA_6   <= 1'b0;
            O_ENA_CPU <= 1'b0;
            O_RESET   <= 1'b1;
            O_PAUSED  <= 1'b0;
        end else begin
            O_ENA_12  <= ena_12_d;
            O_ENA_6   <= ena_6_d;
            O_ENA_CPU <= ena_cpu_d;
            O_RESET   <= reset_d;
            O_PAUSED  <= paused_d;
        end
    end

    assign O_STATE = state;

endmodule

// File: tb/tb_pacman_clk_ctrl.sv
// Directed bench for pacman_clk_ctrl: start-up, enable ratios, pause alignment,
// lock glitches, pause held through HOLD and asynchronous reset.
module tb_pacman_clk_ctrl;

    localparam int LOCK_CYCLES = 4;
    localparam int RESET_HOLD  = 8;
    localparam int HOLD_LEN    = 3 * RESET_HOLD;

    logic       I_CLK = 1'b0;
    logic       I_RESET_L = 1'b0;
    logic       I_LOCKED = 1'b1;
    logic       I_PAUSE = 1'b0;
    logic       O_ENA_12, O_ENA_6, O_ENA_CPU, O_RESET, O_PAUSED;
    logic [2:0] O_STATE;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int base   = 0;

    pacman_clk_ctrl #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .RESET_HOLD  (RESET_HOLD)
    ) dut (
        .I_CLK     (I_CLK),
        .I_RESET_L (I_RESET_L),
        .I_LOCKED  (I_LOCKED),
        .I_PAUSE   (I_PAUSE),
        .O_ENA_12  (O_ENA_12),
        .O_ENA_6   (O_ENA_6),
        .O_ENA_CPU (O_ENA_CPU),
        .O_RESET   (O_RESET),
        .O_PAUSED  (O_PAUSED),
        .O_STATE   (O_STATE)
    );

    always #5 I_CLK = ~I_CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    task automatic step();
        @(posedge I_CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic rst,
                            input logic paused, input logic e12, input logic e6,
                            input logic cpu);
        chk({tag, "_state"},  32'(O_STATE),   32'(st));
        chk({tag, "_reset"},  32'(O_RESET),   32'(rst));
        chk({tag, "_paused"}, 32'(O_PAUSED),  32'(paused));
        chk({tag, "_ena12"},  32'(O_ENA_12),  32'(e12));
        chk({tag, "_ena6"},   32'(O_ENA_6),   32'(e6));
        chk({tag, "_cpu"},    32'(O_ENA_CPU), 32'(cpu));
    endtask

    // Six-cycle RUN pattern counted from a ph=0 CPU-enable cycle.
    task automatic chk_run_cycle();
        int k;
        k = (cyc - base) % 6;
        chk_outs("run", 3'd3, 1'b0, 1'b0, (k != 2) && (k != 5), (k == 0) || (k == 3), k == 0);
    endtask

    task automatic wait_k(input int a);
        while (((cyc - base) % 6) != a) begin
            step();
            chk_run_cycle();
        end
    endtask

    // Enter with cyc == h-1; checks HOLD from cycle h through the first RUN cycle.
    task automatic hold_to_run(input int h);
        int k;
        while (cyc < h + HOLD_LEN) begin
            step();
            k = (cyc - h) % 6;
            chk_outs("hold", (cyc < h + HOLD_LEN) ? 3'd2 : 3'd3, cyc < h + HOLD_LEN, 1'b0,
                     (k != 2) && (k != 5), (k == 0) || (k == 3), k == 0);
        end
        base = h;
    endtask

    // Enter with I_RESET_L low and I_LOCKED high.
    task automatic startup();
        @(posedge I_CLK);
        #4;
        I_RESET_L = 1'b1;
        cyc = 0;
        for (int i = 1; i < 7; i++) begin
            step();
            chk_outs("start", (cyc < 3) ? 3'd0 : 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        hold_to_run(7);
    endtask

    initial begin
        int c12, c6, ccpu, cbad, c, q;

        // Reset values while held in reset.
        I_RESET_L = 1'b0;
        step();
        step();
        chk_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start-up: FILTER at 3, HOLD at 7, reset falls on the 9th ENA_6 (cycle 31).
        startup();

        // Steady-state ratios over 3000 RUN cycles.
        c12 = 0; c6 = 0; ccpu = 0; cbad = 0;
        repeat (3000) begin
            step();
            c12  += int'(O_ENA_12);
            c6   += int'(O_ENA_6);
            ccpu += int'(O_ENA_CPU);
            if (O_ENA_CPU && !O_ENA_6) cbad++;
        end
        chk("ratio_ena12", 32'(c12), 32'd2000);
        chk("ratio_ena6", 32'(c6), 32'd1000);
        chk("ratio_cpu", 32'(ccpu), 32'd500);
        chk("cpu_without_ena6", 32'(cbad), 32'd0);
        chk("ratio_state", 32'(O_STATE), 32'd3);

        // Pause requested at each of the six phase/toggle alignments.
        for (int a = 0; a < 6; a++) begin
            wait_k(a);
            I_PAUSE = 1'b1;
            c = cyc;
            q = c + 2;
            while (((q - base) % 6) != 5) q++;
            while (cyc < q) begin
                step();
                chk_run_cycle();
            end
            step();
            chk_outs("pause_in", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            repeat (2) begin
                step();
                chk_outs("pause_hold", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            I_PAUSE = 1'b0;
            repeat (2) begin
                step();
                chk_outs("pause_rel", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            step();
            chk_outs("resume", 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            base = cyc;
        end

        // Lock low for 3 cycles in RUN, then a 1-cycle glitch in FILTER.
        wait_k(1);
        I_LOCKED = 1'b0;
        step(); chk_run_cycle();
        step(); chk_run_cycle();
        step(); chk_outs("lock_loss", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        I_LOCKED = 1'b1;
        step(); chk_outs("relock_wait", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); chk_outs("relock_wait", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); chk_outs("filter", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        I_LOCKED = 1'b0;
        step(); chk_outs("filter", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        I_LOCKED = 1'b1;
        step(); chk_outs("filter", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); chk_outs("glitch_wait", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        I_PAUSE = 1'b1;
        repeat (4) begin
            step();
            chk_outs("refilter", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Pause held from before HOLD: ignored until RUN, taken at first boundary.
        hold_to_run(cyc + 1);
        repeat (5) begin
            step();
            chk_run_cycle();
        end
        step();
        chk_outs("hold_pause", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        I_PAUSE = 1'b0;
        repeat (2) begin
            step();
            chk_outs("hold_pause_rel", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step();
        chk_outs("hold_pause_resume", 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        base = cyc;

        // Asynchronous reset between clock edges mid-RUN, then full restart.
        repeat (4) begin
            step();
            chk_run_cycle();
        end
        #3;
        I_RESET_L = 1'b0;
        #1;
        chk_outs("async_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        startup();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
